// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle microprocessor.
//   opcode_e : 4-bit instruction opcodes (values 10-14 are deliberately unassigned)
//   state_e  : FETCH/EXEC/WB sequencer states plus IDLE and HALTED
// The bench uses the opcode_e members directly as its opcode constants.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LDI  = 4'd6,
    OP_JMP  = 4'd7,
    OP_JZ   = 4'd8,
    OP_JNZ  = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    HALTED
  } state_e;

  // Only the five ALU opcodes touch the Z/V flags and use the ALU result.
  function automatic logic isAluOp(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core.
//   a_i, b_i : operands (a = regs[rd], b = regs[rs])
//   op_i     : opcode; only ADD/SUB/AND/OR/XOR produce a meaningful result
//   y_o      : result, modulo 2**DATA_WIDTH
//   z_o      : result is zero
//   v_o      : signed overflow for ADD/SUB, 0 for the logic ops
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  opcode_e               op_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  z_o,
  output logic                  v_o
);

  localparam int MSB = DATA_WIDTH - 1;

  always_comb begin
    y_o = '0;
    v_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o = a_i + b_i;
        // Overflow when both operands share a sign the result does not.
        v_o = (a_i[MSB] == b_i[MSB]) && (y_o[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        y_o = a_i - b_i;
        // Overflow when operand signs differ and the result flips away from a.
        v_o = (a_i[MSB] != b_i[MSB]) && (y_o[MSB] != a_i[MSB]);
      end
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
    z_o = (y_o == '0);
  end

endmodule

// File: rtl/multicycle_microprocessor.sv
// Multi-cycle microprocessor: every instruction takes FETCH, EXEC and WB.
//   clk_i           : rising-edge clock
//   rst_ni          : asynchronous active-low reset (program RAM is not reset)
//   prog_we_i       : program RAM write strobe, honoured only in IDLE/HALTED
//   prog_addr_i     : program RAM write address
//   prog_data_i     : program RAM write data, {op, rd, rs, imm}
//   start_i         : begin execution at pc 0 (ignored while busy)
//   result_o        : last value written to a register
//   zero_flag_o     : Z from the last ALU op
//   overflow_flag_o : signed V from the last ALU op
//   pc_o            : program counter
//   busy_o          : sequencer is in FETCH/EXEC/WB
//   halted_o        : sequencer is in HALTED
//   illegal_op_o    : sticky, an undefined opcode was executed since start
//   instr_count_o   : instructions retired since start (HALT not counted)
module multicycle_microprocessor
  import cpu_pkg::*;
#(
  parameter  int ADDR_WIDTH = 6,
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REGS   = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int RA_W       = $clog2(NUM_REGS),
  localparam int INSTR_W    = 4 + 2 * RA_W + DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  prog_we_i,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  input  logic [INSTR_W-1:0]    prog_data_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_flag_o,
  output logic                  overflow_flag_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  illegal_op_o,
  output logic [CNT_WIDTH-1:0]  instr_count_o
);

  localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PcOne  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CntOne = CNT_WIDTH'(1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]      ir_q;
  logic [DATA_WIDTH-1:0]   regFile_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   aluRes_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q, ovf_q, illegal_q;
  logic [CNT_WIDTH-1:0]    instrCnt_q;
  logic [INSTR_W-1:0]      progRam [MEM_SIZE];

  opcode_e                 op;
  logic [RA_W-1:0]         rd, rs;
  logic [DATA_WIDTH-1:0]   imm;
  logic [DATA_WIDTH-1:0]   aluY;
  logic                    aluZ, aluV;
  logic                    busy;

  assign op   = opcode_e'(ir_q[INSTR_W-1 -: 4]);
  assign rd   = ir_q[DATA_WIDTH + 2*RA_W - 1 -: RA_W];
  assign rs   = ir_q[DATA_WIDTH + RA_W - 1 -: RA_W];
  assign imm  = ir_q[DATA_WIDTH-1:0];
  assign busy = (state_q == FETCH) || (state_q == EXEC) || (state_q == WB);

  cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) uAlu (
    .a_i (regFile_q[rd]),
    .b_i (regFile_q[rs]),
    .op_i(op),
    .y_o (aluY),
    .z_o (aluZ),
    .v_o (aluV)
  );

  // Next pc for the instruction in WB. Z is only written by ALU ops, so the
  // registered flag is exactly the value that stood before a jump.
  always_comb begin
    pc_d = pc_q + PcOne;
    case (op)
      OP_JMP:  pc_d = imm[ADDR_WIDTH-1:0];
      OP_JZ:   if (zero_q)  pc_d = imm[ADDR_WIDTH-1:0];
      OP_JNZ:  if (!zero_q) pc_d = imm[ADDR_WIDTH-1:0];
      default: pc_d = pc_q + PcOne;
    endcase
  end

  // Program RAM has no reset so a loaded program survives rst_ni. Writes are
  // locked out while the core runs; a write alongside start lands on the same
  // edge that enters FETCH, so the first fetch already sees it.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && !busy) begin
      progRam[prog_addr_i] <= prog_data_i;
    end
  end

  // Sequencer plus datapath registers. The ALU result is captured in EXEC
  // and committed only in WB, so a reset before WB leaves no partial write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      aluRes_q   <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      instrCnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (start_i) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            instrCnt_q <= '0;
            illegal_q  <= 1'b0;
          end
        end
        FETCH: begin
          ir_q    <= progRam[pc_q];
          state_q <= EXEC;
        end
        EXEC: begin
          if (isAluOp(op)) begin
            aluRes_q <= aluY;
            zero_q   <= aluZ;
            ovf_q    <= aluV;
          end
          state_q <= WB;
        end
        WB: begin
          if (op == OP_HALT) begin
            state_q <= HALTED;
          end else begin
            state_q    <= FETCH;
            pc_q       <= pc_d;
            instrCnt_q <= instrCnt_q + CntOne;
            case (op)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                regFile_q[rd] <= aluRes_q;
                result_q      <= aluRes_q;
              end
              OP_LDI: begin
                regFile_q[rd] <= imm;
                result_q      <= imm;
              end
              OP_NOP, OP_JMP, OP_JZ, OP_JNZ: ;
              // Only the unassigned opcodes 10-14 reach here.
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o        = result_q;
  assign zero_flag_o     = zero_q;
  assign overflow_flag_o = ovf_q;
  assign pc_o            = pc_q;
  assign busy_o          = busy;
  assign halted_o        = (state_q == HALTED);
  assign illegal_op_o    = illegal_q;
  assign instr_count_o   = instrCnt_q;

endmodule

// File: tb/tb_multicycle_microprocessor.sv
// Directed self-checking bench for multicycle_microprocessor.
// Programs are loaded through the write port, run to HALT, and the
// architectural outputs are compared against hand-computed values.
module tb_multicycle_microprocessor;
  import cpu_pkg::*;

  localparam int AW = 6;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic [7:0]    result;
  logic          zeroFlag, ovfFlag, busy, halted, illegalOp;
  logic [AW-1:0] pc;
  logic [15:0]   instrCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_microprocessor dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .prog_we_i      (prog_we),
    .prog_addr_i    (prog_addr),
    .prog_data_i    (prog_data),
    .start_i        (start),
    .result_o       (result),
    .zero_flag_o    (zeroFlag),
    .overflow_flag_o(ovfFlag),
    .pc_o           (pc),
    .busy_o         (busy),
    .halted_o       (halted),
    .illegal_op_o   (illegalOp),
    .instr_count_o  (instrCount)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic writeInstr(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until HALTED, bounded so a stuck core still ends the run.
  task automatic waitHalt(input int maxCycles, output int cycles);
    cycles = 0;
    while (!halted && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int maxPc;
    rst_ni    = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_count", 32'(instrCount), 32'h0);
    checkOutput("rst_flags", 32'({zeroFlag, ovfFlag, illegalOp}), 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    $display("[TB] LDI/LDI/ADD/HALT");
    writeInstr(0, mk(OP_LDI, 0, 0, 8'h05));
    writeInstr(1, mk(OP_LDI, 1, 0, 8'h03));
    writeInstr(2, mk(OP_ADD, 0, 1, 8'h00));
    writeInstr(3, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t1_halted", 32'(halted), 32'h1);
    checkOutput("t1_cycles", 32'(cyc), 32'd12);
    checkOutput("t1_result", 32'(result), 32'h08);
    checkOutput("t1_zv", 32'({zeroFlag, ovfFlag}), 32'h0);
    checkOutput("t1_count", 32'(instrCount), 32'd3);
    checkOutput("t1_pc", 32'(pc), 32'd3);

    $display("[TB] signed overflow then SUB to zero");
    writeInstr(0, mk(OP_LDI, 0, 0, 8'h7F));
    writeInstr(1, mk(OP_LDI, 1, 0, 8'h01));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t2_result", 32'(result), 32'h80);
    checkOutput("t2_v", 32'(ovfFlag), 32'h1);
    checkOutput("t2_z", 32'(zeroFlag), 32'h0);
    writeInstr(0, mk(OP_SUB, 0, 0, 8'h00));
    writeInstr(1, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t2b_result", 32'(result), 32'h00);
    checkOutput("t2b_zv", 32'({zeroFlag, ovfFlag}), 32'b10);
    checkOutput("t2b_count", 32'(instrCount), 32'd1);

    $display("[TB] JZ taken, upper imm bits ignored");
    writeInstr(1, mk(OP_JZ, 0, 0, 8'hCA));
    writeInstr(2, mk(OP_HALT, 0, 0, 8'h00));
    writeInstr(10, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t3_halted", 32'(halted), 32'h1);
    checkOutput("t3_pc", 32'(pc), 32'd10);
    checkOutput("t3_count", 32'(instrCount), 32'd2);

    $display("[TB] JNZ written together with start falls through");
    prog_we   = 1'b1;
    prog_addr = 1;
    prog_data = mk(OP_JNZ, 0, 0, 8'hCA);
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    waitHalt(100, cyc);
    checkOutput("t3b_pc", 32'(pc), 32'd2);
    checkOutput("t3b_count", 32'(instrCount), 32'd2);

    $display("[TB] JNZ taken, JZ not taken, JMP");
    writeInstr(0, mk(OP_LDI, 0, 0, 8'h01));
    writeInstr(1, mk(OP_OR, 0, 0, 8'h00));
    writeInstr(2, mk(OP_JNZ, 0, 0, 8'h05));
    writeInstr(3, mk(OP_HALT, 0, 0, 8'h00));
    writeInstr(5, mk(OP_JZ, 0, 0, 8'h3F));
    writeInstr(6, mk(OP_JMP, 0, 0, 8'h48));
    writeInstr(8, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t3c_pc", 32'(pc), 32'd8);
    checkOutput("t3c_count", 32'(instrCount), 32'd5);
    checkOutput("t3c_result", 32'(result), 32'h01);

    $display("[TB] illegal opcode, writes and start while busy");
    writeInstr(0, mk(OP_LDI, 1, 0, 8'h40));
    writeInstr(1, mk(OP_ADD, 1, 1, 8'h00));
    writeInstr(2, mk(4'd12, 1, 1, 8'hFF));
    writeInstr(3, mk(OP_HALT, 0, 0, 8'h00));
    writeInstr(4, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 3;
    prog_data = mk(OP_NOP, 0, 0, 8'h00);
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    waitHalt(100, cyc);
    checkOutput("t5_cycles", 32'(cyc), 32'd10);
    checkOutput("t5_pc", 32'(pc), 32'd3);
    checkOutput("t5_illegal", 32'(illegalOp), 32'h1);
    checkOutput("t5_result", 32'(result), 32'h80);
    checkOutput("t5_zv", 32'({zeroFlag, ovfFlag}), 32'b01);
    checkOutput("t5_count", 32'(instrCount), 32'd3);

    $display("[TB] logic ops clear V, start clears illegal_op");
    writeInstr(0, mk(OP_LDI, 0, 0, 8'hC3));
    writeInstr(1, mk(OP_LDI, 1, 0, 8'h5A));
    writeInstr(2, mk(OP_OR, 0, 1, 8'h00));
    writeInstr(3, mk(OP_AND, 0, 1, 8'h00));
    writeInstr(4, mk(OP_XOR, 0, 1, 8'h00));
    writeInstr(5, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    checkOutput("t7_illegal_clr", 32'(illegalOp), 32'h0);
    waitHalt(100, cyc);
    checkOutput("t7_result", 32'(result), 32'h00);
    checkOutput("t7_zv", 32'({zeroFlag, ovfFlag}), 32'b10);
    checkOutput("t7_count", 32'(instrCount), 32'd5);

    $display("[TB] reset during EXEC of ADD");
    writeInstr(0, mk(OP_LDI, 0, 0, 8'h05));
    writeInstr(1, mk(OP_LDI, 1, 0, 8'h03));
    writeInstr(2, mk(OP_ADD, 0, 1, 8'h00));
    writeInstr(3, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    cyc = 0;
    while (pc != 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_pc", 32'(pc), 32'h0);
    checkOutput("t6_result", 32'(result), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    writeInstr(0, mk(OP_OR, 0, 1, 8'h00));
    writeInstr(1, mk(OP_HALT, 0, 0, 8'h00));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t6_regs_zero", 32'(result), 32'h00);
    checkOutput("t6_regs_z", 32'(zeroFlag), 32'h1);
    writeInstr(0, mk(OP_LDI, 0, 0, 8'h05));
    writeInstr(1, mk(OP_LDI, 1, 0, 8'h03));
    applyStimulus();
    waitHalt(100, cyc);
    checkOutput("t6_rerun_result", 32'(result), 32'h08);
    checkOutput("t6_rerun_count", 32'(instrCount), 32'd3);
    checkOutput("t6_rerun_pc", 32'(pc), 32'd3);

    $display("[TB] all-NOP RAM, pc wrap");
    for (int a = 0; a < 64; a++) begin
      writeInstr(AW'(a), mk(OP_NOP, 0, 0, 8'h00));
    end
    applyStimulus();
    maxPc = 0;
    cyc   = 0;
    while (instrCount != 16'd64 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (int'(pc) > maxPc) maxPc = int'(pc);
    end
    checkOutput("t4_count", 32'(instrCount), 32'd64);
    checkOutput("t4_pc_wrap", 32'(pc), 32'd0);
    checkOutput("t4_max_pc", 32'(maxPc), 32'd63);
    checkOutput("t4_busy", 32'(busy), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
